// File: rtl/jtopl_pkg.sv
// rtl/jtopl_pkg.sv - shared register map constants and update-strobe enum
package jtopl_pkg;

  localparam logic [7:0] REG_MULT  = 8'h20;
  localparam logic [7:0] REG_KSLTL = 8'h40;
  localparam logic [7:0] REG_ARDR  = 8'h60;
  localparam logic [7:0] REG_SLRR  = 8'h80;
  localparam logic [7:0] REG_FNLO  = 8'hA0;
  localparam logic [7:0] REG_FNHI  = 8'hB0;
  localparam logic [7:0] REG_FBCON = 8'hC0;
  localparam logic [7:0] REG_RHY   = 8'hBD;
  localparam logic [7:0] REG_TEST  = 8'h01;
  localparam logic [7:0] REG_WAV   = 8'hE0;

  localparam int UP_N = 8;

  // Values 0..7 double as bit positions in the held strobe vector.
  typedef enum logic [3:0] {
    UP_FBCON  = 4'd0,
    UP_FNUMLO = 4'd1,
    UP_FNUMHI = 4'd2,
    UP_MULT   = 4'd3,
    UP_KSLTL  = 4'd4,
    UP_ARDR   = 4'd5,
    UP_SLRR   = 4'd6,
    UP_WAV    = 4'd7,
    UP_NONE   = 4'd8
  } up_e;

endpackage

// File: rtl/jtopl_wr_busy.sv
// rtl/jtopl_wr_busy.sv - reloadable cen down-counter driving the CPU busy flag
module jtopl_wr_busy #(
  parameter int BUSY_CYC = 36
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cen,
  input  logic load,
  output logic busy
);

  localparam int W = $clog2(BUSY_CYC + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= W'(BUSY_CYC);
    end else if (cen && cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/jtopl_wrdec.sv
// rtl/jtopl_wrdec.sv - CPU write decoder: strobes, globals, busy timer
// JTOPL2_EN enables the 0xE0 wave-select decode and reg 0x01 wave_mode.
module jtopl_wrdec
  import jtopl_pkg::*;
#(
  parameter int BUSY_CYC = 36
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic       cs_n,
  input  logic       wr_n,
  input  logic       addr,
  input  logic [7:0] din,
  input  logic       zero,
  output logic [7:0] dout,
  output logic       busy,
  output logic       write,
  output logic [7:0] reg_din,
  output logic [1:0] sel_group,
  output logic [2:0] sel_sub,
  output logic       up_fbcon,
  output logic       up_fnumlo,
  output logic       up_fnumhi,
  output logic       up_mult,
  output logic       up_ksl_tl,
  output logic       up_ar_dr,
  output logic       up_sl_rr,
  output logic       up_wav,
  output logic       rhy_en,
  output logic [4:0] rhy_kon,
  output logic       am_dep,
  output logic       vib_dep,
  output logic       wave_mode
);

  logic            act, prev_act, acc, data_wr;
  logic [7:0]      sel_reg;
  logic [UP_N-1:0] up;
  logic [1:0]      zcnt;

  up_e             dec, op_st, ch_st;
  logic [1:0]      dec_grp;
  logic [2:0]      dec_sub;
  logic [4:0]      off;
  logic [3:0]      n;

  assign act     = !cs_n && !wr_n;
  assign acc     = act && !prev_act;
  assign data_wr = acc && addr;

  always_comb begin
    dec     = UP_NONE;
    dec_grp = '0;
    dec_sub = '0;
    off     = sel_reg[4:0];
    n       = sel_reg[3:0];
    case (sel_reg[7:5])
      REG_MULT[7:5]:  op_st = UP_MULT;
      REG_KSLTL[7:5]: op_st = UP_KSLTL;
      REG_ARDR[7:5]:  op_st = UP_ARDR;
      REG_SLRR[7:5]:  op_st = UP_SLRR;
`ifdef JTOPL2_EN
      REG_WAV[7:5]:   op_st = UP_WAV;
`endif
      default:        op_st = UP_NONE;
    endcase
    case (sel_reg[7:4])
      REG_FNLO[7:4]:  ch_st = UP_FNUMLO;
      REG_FNHI[7:4]:  ch_st = UP_FNUMHI;
      REG_FBCON[7:4]: ch_st = UP_FBCON;
      default:        ch_st = UP_NONE;
    endcase
    // Operator slots 6,7 of each group and group 3 do not exist.
    if (op_st != UP_NONE && off[2:0] <= 3'd5 && off[4:3] != 2'd3) begin
      dec     = op_st;
      dec_grp = off[4:3];
      dec_sub = off[2:0];
    end else if (ch_st != UP_NONE && n <= 4'd8) begin
      dec     = ch_st;
      dec_grp = 2'(n / 4'd3);
      dec_sub = 3'(n % 4'd3);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_act  <= 1'b1;
      sel_reg   <= '0;
      reg_din   <= '0;
      write     <= 1'b0;
      up        <= '0;
      zcnt      <= '0;
      sel_group <= '0;
      sel_sub   <= '0;
      rhy_en    <= 1'b0;
      rhy_kon   <= '0;
      am_dep    <= 1'b0;
      vib_dep   <= 1'b0;
      wave_mode <= 1'b0;
    end else begin
      prev_act <= act;
      write    <= data_wr;
      if (acc && !addr) sel_reg <= din;
      if (data_wr) begin
        reg_din <= din;
        zcnt    <= '0;
        up      <= '0;
        if (dec != UP_NONE) begin
          up[dec[2:0]] <= 1'b1;
          sel_group    <= dec_grp;
          sel_sub      <= dec_sub;
        end
        if (sel_reg == REG_RHY) begin
          {am_dep, vib_dep, rhy_en, rhy_kon} <= din;
        end
`ifdef JTOPL2_EN
        if (sel_reg == REG_TEST) wave_mode <= din[5];
`else
        wave_mode <= 1'b0;
`endif
      end else begin
        // Two start-of-round markers guarantee a complete slot pass.
        if (zcnt == 2'd2) up <= '0;
        if (cen && zero && zcnt != 2'd2) zcnt <= zcnt + 2'd1;
      end
    end
  end

  jtopl_wr_busy #(.BUSY_CYC(BUSY_CYC)) u_busy (
    .clk   (clk),
    .rst_n (rst_n),
    .cen   (cen),
    .load  (data_wr),
    .busy  (busy)
  );

  assign dout      = {busy, 7'b0};
  assign up_fbcon  = up[UP_FBCON];
  assign up_fnumlo = up[UP_FNUMLO];
  assign up_fnumhi = up[UP_FNUMHI];
  assign up_mult   = up[UP_MULT];
  assign up_ksl_tl = up[UP_KSLTL];
  assign up_ar_dr  = up[UP_ARDR];
  assign up_sl_rr  = up[UP_SLRR];
  assign up_wav    = up[UP_WAV];

endmodule

// File: tb/tb_jtopl_wrdec.sv
// tb/tb_jtopl_wrdec.sv - randomized bench for jtopl_wrdec with behavioural model
module tb_jtopl_wrdec;

  localparam int BUSY = 36;
`ifdef JTOPL2_EN
  localparam bit WAV_EN = 1'b1;
`else
  localparam bit WAV_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0, cen = 1'b0, cs_n = 1'b1, wr_n = 1'b1, addr = 1'b0, zero = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout, reg_din;
  logic busy, write, rhy_en, am_dep, vib_dep, wave_mode;
  logic [1:0] sel_group;
  logic [2:0] sel_sub;
  logic [4:0] rhy_kon;
  logic up_fbcon, up_fnumlo, up_fnumhi, up_mult, up_ksl_tl, up_ar_dr, up_sl_rr, up_wav;
  logic [7:0] upv;

  int n_tests = 0, n_fail = 0;
  bit rand_bg = 1'b0;

  always #5 clk = ~clk;

  jtopl_wrdec #(.BUSY_CYC(BUSY)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .cs_n(cs_n), .wr_n(wr_n), .addr(addr),
    .din(din), .zero(zero), .dout(dout), .busy(busy), .write(write),
    .reg_din(reg_din), .sel_group(sel_group), .sel_sub(sel_sub),
    .up_fbcon(up_fbcon), .up_fnumlo(up_fnumlo), .up_fnumhi(up_fnumhi),
    .up_mult(up_mult), .up_ksl_tl(up_ksl_tl), .up_ar_dr(up_ar_dr),
    .up_sl_rr(up_sl_rr), .up_wav(up_wav), .rhy_en(rhy_en), .rhy_kon(rhy_kon),
    .am_dep(am_dep), .vib_dep(vib_dep), .wave_mode(wave_mode)
  );

  // bit order: fbcon, fnumlo, fnumhi, mult, ksl_tl, ar_dr, sl_rr, wav
  assign upv = {up_wav, up_sl_rr, up_ar_dr, up_ksl_tl, up_mult, up_fnumhi, up_fnumlo, up_fbcon};

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: state described as "what the CPU last wrote"
  int m_sel = 0, m_din = 0, m_grp = 0, m_sub = 0, m_busy = 0, m_zeros = 0;
  bit m_prev = 1'b1, m_write = 1'b0, m_am = 0, m_vib = 0, m_rhy = 0, m_wave = 0;
  bit [4:0] m_kon = 0;
  bit [7:0] m_up = 0;

  task automatic model_step();
    int op_base[5] = '{32'h20, 32'h40, 32'h60, 32'h80, 32'hE0};
    int op_bit[5]  = '{3, 4, 5, 6, 7};
    int ch_base[3] = '{32'hA0, 32'hB0, 32'hC0};
    int ch_bit[3]  = '{1, 2, 0};
    bit act, acc;
    int o;
    if (!rst_n) begin
      m_sel = 0; m_din = 0; m_grp = 0; m_sub = 0; m_busy = 0; m_zeros = 0;
      m_prev = 1'b1; m_write = 0; m_am = 0; m_vib = 0; m_rhy = 0; m_wave = 0;
      m_kon = 0; m_up = 0;
      return;
    end
    act = !cs_n && !wr_n;
    acc = act && !m_prev;
    m_prev = act;
    m_write = acc && addr;
    if (acc && !addr) m_sel = int'(din);
    if (m_write) begin
      m_din = int'(din); m_up = 0; m_zeros = 0; m_busy = BUSY;
      for (int i = 0; i < 5; i++) begin
        if ((i < 4 || WAV_EN) && m_sel >= op_base[i] && m_sel <= op_base[i] + 21) begin
          o = m_sel - op_base[i];
          if (o % 8 <= 5) begin
            m_up[op_bit[i]] = 1'b1; m_grp = o / 8; m_sub = o % 8;
          end
        end
      end
      for (int i = 0; i < 3; i++) begin
        if (m_sel >= ch_base[i] && m_sel <= ch_base[i] + 8) begin
          o = m_sel - ch_base[i];
          m_up[ch_bit[i]] = 1'b1; m_grp = o / 3; m_sub = o % 3;
        end
      end
      if (m_sel == 32'hBD) begin
        m_am = din[7]; m_vib = din[6]; m_rhy = din[5]; m_kon = din[4:0];
      end
      if (m_sel == 32'h01 && WAV_EN) m_wave = din[5];
    end else begin
      if (m_zeros >= 2) m_up = 0;
      if (cen && zero && m_zeros < 2) m_zeros++;
      if (cen && m_busy > 0) m_busy--;
    end
  endtask

  always @(posedge clk) begin
    logic [39:0] got, exp;
    model_step();
    #1;
    got = {dout, busy, write, reg_din, sel_group, sel_sub, upv, am_dep, vib_dep, rhy_en, rhy_kon, wave_mode};
    exp = {(m_busy != 0), 7'b0, (m_busy != 0), m_write, 8'(m_din), 2'(m_grp), 3'(m_sub), m_up,
           m_am, m_vib, m_rhy, m_kon, m_wave};
    chk("cycle_model", 64'(got), 64'(exp));
  end

  task automatic tick();
    @(negedge clk);
    if (rand_bg) begin
      cen  = 1'($urandom_range(0, 1));
      zero = ($urandom_range(0, 4) == 0);
    end
  endtask

  task automatic bus_wr(input logic a, input logic [7:0] d, input int hold, input int gap);
    tick();
    cs_n = 1'b0; wr_n = 1'b0; addr = a; din = d;
    repeat (hold) tick();
    cs_n = 1'b1; wr_n = 1'b1;
    repeat (gap) tick();
  endtask

  task automatic count_busy(output int c);
    c = 0;
    while (busy && c < 100) begin
      c++;
      tick();
    end
  endtask

  initial begin
    int c;
    logic [7:0] a;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_dout", dout, 0);
    chk("rst_up", upv, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sel", {sel_group, sel_sub, reg_din}, 0);

    cen = 1'b1; zero = 1'b0;
    bus_wr(1'b0, 8'h43, 1, 0);
    bus_wr(1'b1, 8'h2A, 1, 0);
    chk("k43_write", write, 1);
    chk("k43_up", upv, 8'b0001_0000);
    chk("k43_grpsub", {sel_group, sel_sub}, {2'd0, 3'd3});
    chk("k43_din", reg_din, 8'h2A);
    tick();
    chk("k43_write_1clk", write, 0);
    count_busy(c);
    chk("k43_busy_len", c, BUSY - 1);

    bus_wr(1'b1, 8'h2A, 1, 0);
    repeat (25) tick();
    chk("reload_busy_pre", busy, 1);
    bus_wr(1'b1, 8'h3C, 1, 0);
    chk("reload_write", write, 1);
    count_busy(c);
    chk("reload_busy_len", c, BUSY);

    bus_wr(1'b0, 8'hA7, 1, 0);
    bus_wr(1'b1, 8'h55, 1, 0);
    chk("a7_up", upv, 8'b0000_0010);
    chk("a7_grpsub", {sel_group, sel_sub}, {2'd2, 3'd1});
    zero = 1'b1; tick(); zero = 1'b0; tick();
    chk("a7_hold1", up_fnumlo, 1);
    zero = 1'b1; tick(); zero = 1'b0;
    chk("a7_hold2", up_fnumlo, 1);
    tick();
    chk("a7_clear", up_fnumlo, 0);

    bus_wr(1'b0, 8'hBD, 2, 1);
    bus_wr(1'b1, 8'hE5, 3, 0);
    chk("bd_fields", {am_dep, vib_dep, rhy_en, rhy_kon}, {1'b1, 1'b1, 1'b1, 5'b00101});
    chk("bd_up", upv, 0);

    bus_wr(1'b0, 8'h26, 1, 0);
    bus_wr(1'b1, 8'hFF, 1, 0);
    chk("k26_up", upv, 0);
    chk("k26_write", write, 1);
    chk("k26_busy", busy, 1);

    bus_wr(1'b0, 8'h20, 1, 0);
    bus_wr(1'b1, 8'h11, 1, 0);
    chk("k20_mult", up_mult, 1);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("rst_mult", up_mult, 0);
    chk("rst_busy2", busy, 0);

    cs_n = 1'b0; wr_n = 1'b0; addr = 1'b1; din = 8'h77; rst_n = 1'b0;
    tick(); rst_n = 1'b1; tick(); tick();
    chk("rst_held_write", {write, busy}, 0);
    cs_n = 1'b1; wr_n = 1'b1; tick();

    bus_wr(1'b0, 8'hE0, 1, 0);
    bus_wr(1'b1, 8'h33, 1, 0);
    chk("e0_wav", up_wav, WAV_EN);
    bus_wr(1'b0, 8'h01, 1, 0);
    bus_wr(1'b1, 8'h20, 1, 0);
    chk("r01_wave", wave_mode, WAV_EN);

    rand_bg = 1'b1;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 5))
        0: a = 8'(32'h20 * $urandom_range(1, 4) + $urandom_range(0, 31));
        1: a = 8'(32'hE0 + $urandom_range(0, 31));
        2: a = 8'(32'hA0 + 32'h10 * $urandom_range(0, 2) + $urandom_range(0, 15));
        3: a = ($urandom_range(0, 1) != 0) ? 8'hBD : 8'h01;
        default: a = 8'($urandom);
      endcase
      if ($urandom_range(0, 2) != 0) bus_wr(1'b0, a, $urandom_range(1, 3), $urandom_range(0, 3));
      bus_wr(1'b1, 8'($urandom), $urandom_range(1, 3), $urandom_range(0, 12));
      if ($urandom_range(0, 39) == 0) begin
        cs_n = 1'($urandom_range(0, 1)); wr_n = 1'b0; addr = 1'b1;
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        cs_n = 1'b1; wr_n = 1'b1;
      end
    end
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
